impuls_scheduler: RTL and testbench

Shares one pulse-stretch output channel among CHANNELS asynchronous impulse inputs in the FDAU optional pulse path. Each input rising edge is synchronised and latched as a pending request. A round-robin arbiter grants one request at a time and drives the 16-bit pulse word high for HOLD_MS millisecond periods, tagging it with the channel index. A guard gap follows each pulse, and requests that arrive while one is already pending are reported as lost. Runs on clk_1MHz alongside the msec timebase.

---
 rtl/impuls_scheduler.sv | 146 ++++++++++++++
 tb/tb_impuls_scheduler.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/impuls_scheduler.sv
// Round-robin scheduler sharing one msec-timed pulse output among several
// asynchronous impulse inputs, with per-channel pending and overrun flags.
module impuls_scheduler #(
   parameter int CHANNELS = 4,
   parameter int HOLD_MS  = 18,
   parameter int GAP_MS   = 2,
   parameter int CW       = $clog2(CHANNELS)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                msec,
   input  logic [CHANNELS-1:0] impuls,
   input  logic                lost_clr,
   output logic [15:0]         imp,
   output logic [CW-1:0]       imp_ch,
   output logic                busy,
   output logic [CHANNELS-1:0] pending,
   output logic [CHANNELS-1:0] lost
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ARB  = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;
   localparam logic [1:0] GAP  = 2'd3;

   localparam logic [4:0] HOLD_LAST = 5'(HOLD_MS - 1);
   localparam logic [4:0] GAP_LAST  = 5'((GAP_MS > 0) ? GAP_MS - 1 : 0);

   logic [CHANNELS-1:0] s1, s2, s3;
   logic [CHANNELS-1:0] edge_det;
   logic [CHANNELS-1:0] grant_mask;
   logic                msec_d;
   logic                msec_rise;
   logic [1:0]          state;
   logic [CW-1:0]       last;
   logic [CW-1:0]       grant;
   logic [CW-1:0]       grant_hi;
   logic [CW-1:0]       grant_lo;
   logic                hi_found;
   logic                lo_found;
   logic [4:0]          ms_cnt;
   logic                imp_on;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1     <= '0;
         s2     <= '0;
         s3     <= '0;
         msec_d <= 1'b0;
      end else begin
         s1     <= impuls;
         s2     <= s1;
         s3     <= s2;
         msec_d <= msec;
      end
   end

   assign edge_det  = s2 & ~s3;
   assign msec_rise = msec & ~msec_d;

   // Round-robin: lowest pending index above last wins, else wrap to the lowest overall.
   always_comb begin
      grant_hi = '0;
      grant_lo = '0;
      hi_found = 1'b0;
      lo_found = 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (pending[i] && !lo_found) begin
            grant_lo = CW'(i);
            lo_found = 1'b1;
         end
         if (pending[i] && (i > 32'(last)) && !hi_found) begin
            grant_hi = CW'(i);
            hi_found = 1'b1;
         end
      end
      grant = hi_found ? grant_hi : grant_lo;
   end

   always_comb begin
      grant_mask = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         grant_mask[i] = (state == ARB) && (grant == CW'(i));
      end
   end

   // A fresh edge outranks both the grant clear and the lost_clr strobe.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pending <= '0;
         lost    <= '0;
      end else begin
         pending <= (pending & ~grant_mask) | edge_det;
         lost    <= (lost & ~{CHANNELS{lost_clr}}) | (edge_det & pending & ~grant_mask);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         last   <= CW'(CHANNELS - 1);
         imp_ch <= '0;
         imp_on <= 1'b0;
         ms_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|pending) state <= ARB;
            end
            ARB: begin
               last   <= grant;
               imp_ch <= grant;
               imp_on <= 1'b1;
               ms_cnt <= '0;
               state  <= HOLD;
            end
            HOLD: begin
               if (msec_rise) begin
                  if (ms_cnt == HOLD_LAST) begin
                     imp_on <= 1'b0;
                     ms_cnt <= '0;
                     state  <= (GAP_MS == 0) ? IDLE : GAP;
                  end else begin
                     ms_cnt <= ms_cnt + 5'd1;
                  end
               end
            end
            GAP: begin
               if (msec_rise) begin
                  if (ms_cnt == GAP_LAST) begin
                     ms_cnt <= '0;
                     state  <= IDLE;
                  end else begin
                     ms_cnt <= ms_cnt + 5'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign imp  = {16{imp_on}};
   assign busy = (state != IDLE);

endmodule

// File: tb/tb_impuls_scheduler.sv
// Bench for impuls_scheduler: vector table, directed corner sequences and
// randomized traffic against a countdown-based behavioural model.
module tb_impuls_scheduler;

   localparam int NCH  = 4;
   localparam int HOLD = 18;
   localparam int GAP  = 2;
   localparam int MSP  = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        msec = 1'b0;
   logic        lost_clr = 1'b0;
   logic [3:0]  impuls = '0;
   logic [15:0] imp;
   logic [1:0]  imp_ch;
   logic        busy;
   logic [3:0]  pending;
   logic [3:0]  lost;

   logic        b_msec = 1'b0;
   logic [3:0]  b_impuls = '0;
   logic [15:0] b_imp;
   logic [1:0]  b_ch;
   logic        b_busy;
   logic [3:0]  b_pend;
   logic [3:0]  b_lost;

   int total = 0;
   int bad   = 0;
   bit ms_auto = 1'b0;
   int ms_ph = 0;

   always #5 clk = ~clk;

   impuls_scheduler #(.CHANNELS(NCH), .HOLD_MS(HOLD), .GAP_MS(GAP)) dut (
      .clock(clk), .reset(rst_n), .msec(msec), .impuls(impuls), .lost_clr(lost_clr),
      .imp(imp), .imp_ch(imp_ch), .busy(busy), .pending(pending), .lost(lost)
   );

   impuls_scheduler #(.CHANNELS(NCH), .HOLD_MS(1), .GAP_MS(0)) dut_b (
      .clock(clk), .reset(rst_n), .msec(b_msec), .impuls(b_impuls), .lost_clr(1'b0),
      .imp(b_imp), .imp_ch(b_ch), .busy(b_busy), .pending(b_pend), .lost(b_lost)
   );

   // behavioural model: sample history queue plus remaining-msec countdowns
   logic [3:0] xq[$];
   bit         m_msec_prev;
   logic [3:0] m_pend, m_lost;
   int         m_last, m_ch, m_pulse_left, m_gap_left;
   bit         m_arb_now;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      xq.delete();
      repeat (3) xq.push_back(4'b0000);
      m_msec_prev  = 1'b0;
      m_pend       = '0;
      m_lost       = '0;
      m_last       = NCH - 1;
      m_ch         = 0;
      m_pulse_left = 0;
      m_gap_left   = 0;
      m_arb_now    = 1'b0;
   endtask

   function automatic int pick();
      for (int d = 1; d <= NCH; d++) begin
         int c;
         c = (m_last + d) % NCH;
         if (m_pend[c]) return c;
      end
      return m_last;
   endfunction

   task automatic model_step();
      logic [3:0] e;
      logic [3:0] clr;
      bit         rise;
      bit         newlost;
      int         g;
      xq.push_front(impuls);
      e = xq[2] & ~xq[3];
      void'(xq.pop_back());
      rise = msec && !m_msec_prev;
      m_msec_prev = msec;
      clr = '0;
      if (m_arb_now) begin
         g = pick();
         clr[g] = 1'b1;
         m_last = g;
         m_ch = g;
         m_arb_now = 1'b0;
         m_pulse_left = HOLD;
      end else if (m_pulse_left > 0) begin
         if (rise) begin
            m_pulse_left--;
            if (m_pulse_left == 0) m_gap_left = GAP;
         end
      end else if (m_gap_left > 0) begin
         if (rise) m_gap_left--;
      end else if (m_pend != 4'b0000) begin
         m_arb_now = 1'b1;
      end
      for (int i = 0; i < NCH; i++) begin
         newlost   = e[i] && m_pend[i] && !clr[i];
         m_pend[i] = (m_pend[i] && !clr[i]) || e[i];
         m_lost[i] = (m_lost[i] && !lost_clr) || newlost;
      end
   endtask

   task automatic tick();
      logic [26:0] act, exp;
      if (ms_auto) begin
         ms_ph++;
         msec = (ms_ph % MSP) < (MSP / 2);
      end
      @(posedge clk);
      #1;
      if (!rst_n) model_reset();
      else model_step();
      act = {imp, imp_ch, busy, pending, lost};
      exp = {(m_pulse_left > 0) ? 16'hFFFF : 16'h0000, 2'(m_ch),
             (m_arb_now || m_pulse_left > 0 || m_gap_left > 0), m_pend, m_lost};
      check("model", 32'(act), 32'(exp));
   endtask

   task automatic ms_pulses(input int n);
      repeat (n) begin
         msec = 1'b1; tick();
         msec = 1'b0; tick(); tick();
      end
   endtask

   task automatic wait_imp(input bit want, input string nm);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 400; n++) begin
         tick();
         if ((imp != 16'h0000) == want) begin
            ok = 1'b1;
            break;
         end
      end
      check(nm, 32'(ok), 32'd1);
   endtask

   task automatic wait_idle(input string nm);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 400; n++) begin
         tick();
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      check(nm, 32'(ok), 32'd1);
   endtask

   typedef struct {
      logic [3:0]  imp_in;
      logic        clr;
      logic [15:0] e_imp;
      logic        e_busy;
      logic [3:0]  e_pend;
      logic [3:0]  e_lost;
      logic [1:0]  e_ch;
   } vec_t;

   vec_t tbl[14];

   initial begin
      logic [3:0] rr_exp[4];
      int extra, nrun, len, zeros, gap0;
      int lens[$];
      int chs[$];
      bit prev, on;

      tbl[0]  = '{4'b0000, 1'b0, 16'h0000, 1'b0, 4'b0000, 4'b0000, 2'd0};
      tbl[1]  = '{4'b0010, 1'b0, 16'h0000, 1'b0, 4'b0000, 4'b0000, 2'd0};
      tbl[2]  = '{4'b0000, 1'b0, 16'h0000, 1'b0, 4'b0000, 4'b0000, 2'd0};
      tbl[3]  = '{4'b0000, 1'b0, 16'h0000, 1'b0, 4'b0010, 4'b0000, 2'd0};
      tbl[4]  = '{4'b0000, 1'b0, 16'h0000, 1'b1, 4'b0010, 4'b0000, 2'd0};
      tbl[5]  = '{4'b0000, 1'b0, 16'hFFFF, 1'b1, 4'b0000, 4'b0000, 2'd1};
      tbl[6]  = '{4'b0010, 1'b0, 16'hFFFF, 1'b1, 4'b0000, 4'b0000, 2'd1};
      tbl[7]  = '{4'b0000, 1'b0, 16'hFFFF, 1'b1, 4'b0000, 4'b0000, 2'd1};
      tbl[8]  = '{4'b0000, 1'b0, 16'hFFFF, 1'b1, 4'b0010, 4'b0000, 2'd1};
      tbl[9]  = '{4'b0000, 1'b0, 16'hFFFF, 1'b1, 4'b0010, 4'b0000, 2'd1};
      tbl[10] = '{4'b0010, 1'b0, 16'hFFFF, 1'b1, 4'b0010, 4'b0000, 2'd1};
      tbl[11] = '{4'b0000, 1'b0, 16'hFFFF, 1'b1, 4'b0010, 4'b0000, 2'd1};
      tbl[12] = '{4'b0000, 1'b0, 16'hFFFF, 1'b1, 4'b0010, 4'b0010, 2'd1};
      tbl[13] = '{4'b0000, 1'b1, 16'hFFFF, 1'b1, 4'b0010, 4'b0000, 2'd1};
      rr_exp[0] = 4'b1110;
      rr_exp[1] = 4'b1100;
      rr_exp[2] = 4'b1000;
      rr_exp[3] = 4'b0000;

      model_reset();
      repeat (3) tick();
      check("rst_imp", 32'(imp), 32'h0);
      check("rst_state", 32'({imp_ch, busy, pending, lost}), 32'h0);
      rst_n = 1'b1;

      // single request on ch1 with msec held low, then overrun on the same channel
      for (int i = 0; i < 14; i++) begin
         impuls   = tbl[i].imp_in;
         lost_clr = tbl[i].clr;
         tick();
         check($sformatf("vec%0d", i), 32'({imp, busy, pending, lost, imp_ch}),
               32'({tbl[i].e_imp, tbl[i].e_busy, tbl[i].e_pend, tbl[i].e_lost, tbl[i].e_ch}));
      end
      impuls = '0;
      lost_clr = 1'b0;

      ms_pulses(17);
      check("hold17", 32'(imp), 32'hFFFF);
      msec = 1'b1; tick();
      check("hold18_imp", 32'(imp), 32'h0);
      check("hold18_busy", 32'(busy), 32'd1);
      msec = 1'b0; tick(); tick();
      ms_pulses(1);
      check("gap1_busy", 32'(busy), 32'd1);
      msec = 1'b1; tick();
      check("gap2_idle", 32'(busy), 32'd0);
      msec = 1'b0; tick();
      check("rearb", 32'({busy, imp}), 32'h10000);
      tick();
      check("ch1_again", 32'({imp, imp_ch}), 32'({16'hFFFF, 2'd1}));

      // three ch2 edges during ch1's pulse
      repeat (3) begin
         impuls = 4'b0100; tick();
         impuls = 4'b0000; tick(); tick();
      end
      tick(); tick();
      check("ovr_pend", 32'(pending), 32'b0100);
      check("ovr_lost", 32'(lost), 32'b0100);
      ms_auto = 1'b1;
      wait_imp(1'b0, "ovr_end1");
      wait_imp(1'b1, "ovr_start2");
      check("ovr_ch2", 32'(imp_ch), 32'd2);
      wait_imp(1'b0, "ovr_end2");
      wait_idle("ovr_idle");
      extra = 0;
      repeat (120) begin
         tick();
         if (imp != 16'h0) extra++;
      end
      check("ovr_once", 32'(extra), 32'd0);
      lost_clr = 1'b1; tick();
      lost_clr = 1'b0;
      check("lost_clr", 32'(lost), 32'd0);

      // round robin from reset
      rst_n = 1'b0; tick(); tick();
      rst_n = 1'b1;
      impuls = 4'b1111; tick();
      impuls = 4'b0000;
      for (int j = 0; j < 4; j++) begin
         wait_imp(1'b1, $sformatf("rr_start%0d", j));
         check($sformatf("rr_ch%0d", j), 32'(imp_ch), 32'(j));
         check($sformatf("rr_pend%0d", j), 32'(pending), 32'(rr_exp[j]));
         wait_imp(1'b0, $sformatf("rr_end%0d", j));
      end
      wait_idle("rr_idle");

      // new ch0 edge lands in the ARB cycle that grants ch0
      ms_auto = 1'b0;
      msec = 1'b0;
      impuls = 4'b0001; tick();
      impuls = 4'b0000; tick();
      impuls = 4'b0001; tick();
      impuls = 4'b0000; tick();
      check("col_arb", 32'({busy, imp}), 32'h10000);
      tick();
      check("col_grant", 32'({imp, imp_ch, pending, lost}), 32'({16'hFFFF, 2'd0, 4'b0001, 4'b0000}));
      ms_auto = 1'b1;
      wait_imp(1'b0, "col_end1");
      wait_imp(1'b1, "col_start2");
      check("col_ch0", 32'(imp_ch), 32'd0);
      check("col_nolost", 32'(lost), 32'd0);

      // asynchronous reset at the 9th msec rise of that pulse
      ms_auto = 1'b0;
      msec = 1'b0;
      impuls = 4'b1000; tick();
      impuls = 4'b0000; tick(); tick(); tick();
      check("pre_rst_pend", 32'(pending), 32'b1000);
      ms_pulses(8);
      msec = 1'b1; tick();
      check("pre_rst_imp", 32'(imp), 32'hFFFF);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst", 32'({imp, busy, pending}), 32'h0);
      msec = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      ms_auto = 1'b1;
      repeat (60) tick();
      check("post_rst_idle", 32'({imp, busy}), 32'h0);
      ms_auto = 1'b0;

      // HOLD_MS=1, GAP_MS=0 instance: two simultaneous requests
      b_impuls = 4'b0011; tick();
      b_impuls = 4'b0000;
      nrun = 0; len = 0; zeros = 0; gap0 = -1; prev = 1'b0;
      for (int c = 0; c < 40; c++) begin
         b_msec = (c % MSP) < (MSP / 2);
         tick();
         on = (b_imp != 16'h0);
         if (on) begin
            if (!prev) begin
               if (nrun == 1) gap0 = zeros;
               nrun++;
               chs.push_back(int'(b_ch));
               len = 0;
            end
            len++;
         end else begin
            if (prev) begin
               lens.push_back(len);
               zeros = 0;
            end
            zeros++;
         end
         prev = on;
      end
      check("b_runs", 32'(nrun >= 2), 32'd1);
      check("b_gap", 32'(gap0), 32'd2);
      check("b_width", 32'((lens.size() > 0) && (lens[0] <= MSP)), 32'd1);
      check("b_ch0", 32'((chs.size() > 0) ? chs[0] : -1), 32'd0);
      check("b_ch1", 32'((chs.size() > 1) ? chs[1] : -1), 32'd1);

      // randomized traffic, model-checked every cycle
      rst_n = 1'b0; tick();
      rst_n = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 2) == 0) msec = ~msec;
         for (int i = 0; i < NCH; i++) begin
            if ($urandom_range(0, 15) == 0) impuls[i] = ~impuls[i];
         end
         lost_clr = ($urandom_range(0, 63) == 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
